instr_readback: RTL and testbench
=================================

Name: instr_readback

Overview:
- Downstream drain stage for instr_register.
- Drives read_pointer over a programmed address window and captures instruction_word one cycle after each address is presented.
- Buffers captured words in a small FIFO and hands them to a consumer (scoreboard/monitor or next pipeline stage) over a valid/ready handshake.
- Reports completion with busy/done.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- NUM_REGS, 32, register-file depth; read_pointer wraps modulo NUM_REGS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a drain; sampled only in IDLE.
- first_addr  input  5  first address of window; captured on accepted start.
- count  input  6  number of entries to read, 0..32; values >32 clamp to 32.
- read_pointer  output  5  address driven to instr_register.
- instruction_word  input  instruction_t  registered read data from instr_register.
- out_valid  output  1  out_word/out_addr hold a valid entry.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out_word  output  instruction_t  captured instruction word.
- out_addr  output  5  address the word was read from.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse: last entry transferred out.
- mismatch  output  1  see Optional Feature.

Behaviour:
- Reset values: read_pointer=0, out_valid=0, out_word='0, out_addr=0, busy=0, done=0, mismatch=0. FIFO and in-flight tracking cleared; FSM→IDLE. Reset mid-drain abandons the drain; no done pulse.
- FSM states: IDLE, ISSUE, FLUSH.
- IDLE:
  - start=1 latches first_addr and clamped count, then sets busy.
  - If count=0: no reads; done pulses next cycle; return to IDLE.
  - Otherwise go to ISSUE with read_pointer=first_addr.
- ISSUE:
  - An issue happens in cycle N when (fifo_count + inflight) < FIFO_DEPTH.
  - The word for read_pointer in cycle N is written into the FIFO at edge N+1 with out_addr tag = that address; inflight is 1 during cycle N+1.
  - On issue, read_pointer increments; 31→0 wrap.
  - Otherwise read_pointer holds: stall, no issue.
  - After the last issue: go to FLUSH.
- FLUSH: wait until inflight=0 and the FIFO is empty. done pulses in the cycle the final entry transfers; busy falls the same edge.
- Sustained throughput is 1 word/cycle with out_ready held high. The first out_valid appears 2 cycles after the start edge.
- FIFO rules:
  - First-word-fall-through.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - out_word/out_addr stay stable while out_valid && !out_ready.
- start while busy is ignored. first_addr/count changes after acceptance are ignored.
- Window crossing 31 wraps: first_addr=30, count=4 reads 30,31,0,1.
- The FIFO never overflows, by construction. An internal assertion checks that no push occurs when full.

Optional Feature:
- Macro: INSTR_READBACK_CHECK_EN.
- With the macro defined:
  - Each FIFO-pop recomputes the expected result from opc/op_a/op_b using the package result rules, widened to rezultat_t.
  - DIV/MOD with op_b=0: expected 0.
  - mismatch is a registered one-cycle pulse the cycle after a transfer whose rez differs from expected.
- Without the macro: mismatch is tied 0 and no checker logic is present.

Decomposition:
- instr_register_pkg holds:
  - opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), operand_t, rezultat_t, instruction_t;
  - new address_t (5-bit);
  - new function calc_result(opcode_t, operand_t, operand_t), returning rezultat_t, shared with the checker and testbench;
  - new enum readback_state_t.
- One sub-module, readback_fifo: parameterised FWFT FIFO with data width = $bits(instruction_t)+5, exposing count.

Test Plan:
- Reset, then preload addr 0..3 with ADD a=5,b=3, start first_addr=0 count=4, out_ready=1 → out_addr 0,1,2,3 on consecutive cycles, each rez=8, done once, busy low afterward.
- first_addr=30, count=4 → out_addr sequence 30,31,0,1.
- count=8, out_ready low for 10 cycles after start → read_pointer stalls after 4 issues, out_word stable. On release, all 8 arrive in order with no loss or duplicates.
- count=0 → no out_valid, done pulse next cycle, busy for exactly 1 cycle. A second start during busy of a count=5 drain is ignored.
- Assert reset_n mid-drain (after 3 of 10 transfers) → out_valid=0 immediately, no done. A fresh start afterward works normally.
- With INSTR_READBACK_CHECK_EN: entry MULT a=6,b=7 with rez forced to 41 → mismatch pulses once. Entry DIV a=9,b=0 with rez 0 → no mismatch.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its readback drain.
// Holds the result rules used by the optional INSTR_READBACK_CHECK_EN checker.
package instr_register_pkg;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    typedef enum logic [2:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;

    typedef logic signed [31:0]       operand_t;
    typedef logic signed [63:0]       rezultat_t;
    typedef logic [ADDR_W-1:0]        address_t;

    typedef struct packed {
        opcode_t   opc;
        operand_t  op_a;
        operand_t  op_b;
        rezultat_t rez;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE, ISSUE, FLUSH
    } readback_state_t;

    function automatic rezultat_t calc_result(
        input opcode_t  opc,
        input operand_t a,
        input operand_t b
    );
        rezultat_t wa;
        rezultat_t wb;
        rezultat_t res;
        wa = rezultat_t'(a);
        wb = rezultat_t'(b);
        case (opc)
            ZERO:    res = '0;
            PASSA:   res = wa;
            PASSB:   res = wb;
            ADD:     res = wa + wb;
            SUB:     res = wa - wb;
            MULT:    res = wa * wb;
            // Division by zero yields 0 rather than X.
            DIV:     res = (wb == '0) ? '0 : wa / wb;
            MOD:     res = (wb == '0) ? '0 : wa % wb;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/readback_fifo.sv
// First-word-fall-through FIFO buffering captured words for the consumer.
// Head entry is visible on o_dout whenever o_empty is low.
module readback_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && o_full && !w_pop)
    );

endmodule

// File: rtl/instr_readback.sv
// Drains a window of instr_register into a FWFT FIFO over valid/ready.
// INSTR_READBACK_CHECK_EN adds a result checker driving mismatch.
module instr_readback
    import instr_register_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_REGS   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  address_t         first_addr,
    input  logic [CNT_W-1:0] count,
    output address_t         read_pointer,
    input  instruction_t     instruction_word,
    output logic             out_valid,
    input  logic             out_ready,
    output instruction_t     out_word,
    output address_t         out_addr,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $bits(instruction_t) + ADDR_W;

    readback_state_t  r_state;
    address_t         r_rd_ptr;
    address_t         r_tag;
    logic [CNT_W-1:0] r_remain;
    logic             r_inflight;

    logic [CW-1:0]    w_fifo_count;
    logic [CW-1:0]    w_occ;
    logic             w_empty;
    logic             w_full;
    logic             w_issue;
    logic             w_pop;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;
    address_t         w_ptr_next;
    logic [DW-1:0]    w_dout;

    assign w_cnt = (count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : count;

    // Reserve a FIFO slot for the word still on its way from the register.
    assign w_occ   = w_fifo_count + CW'(r_inflight);
    assign w_issue = (r_state == ISSUE) && (w_occ < CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && out_ready;

    assign w_ptr_next = (r_rd_ptr == address_t'(NUM_REGS - 1)) ?
                        '0 : r_rd_ptr + 1'b1;

    // Empty in FLUSH only happens for a zero-length drain.
    assign w_last = (r_state == FLUSH) && !r_inflight &&
                    (w_empty || (w_fifo_count == CW'(1) && w_pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_tag      <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_tag      <= r_rd_ptr;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rd_ptr <= first_addr;
                        r_remain <= w_cnt;
                        r_state  <= (w_cnt == '0) ? FLUSH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_rd_ptr <= w_ptr_next;
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == CNT_W'(1)) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    readback_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (r_inflight),
        .i_din   ({instruction_word, r_tag}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_fifo_count)
    );

    assign read_pointer = r_rd_ptr;
    assign out_valid    = !w_empty;
    assign out_word     = w_dout[DW-1:ADDR_W];
    assign out_addr     = w_dout[ADDR_W-1:0];
    assign busy         = (r_state != IDLE);
    assign done         = w_last;

`ifdef INSTR_READBACK_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_pop && (out_word.rez != calc_result(
                out_word.opc, out_word.op_a, out_word.op_b));
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_instr_readback.sv
// Bench for instr_readback: table-driven drains, corner sequences, random runs.
// Expected stream comes from a window/array model of the register file.
module tb_instr_readback;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    address_t     out_addr;
    logic         busy;
    logic         done;
    logic         mismatch;

    instr_readback #(
        .FIFO_DEPTH (4),
        .NUM_REGS   (32)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word         (out_word),
        .out_addr         (out_addr),
        .busy             (busy),
        .done             (done),
        .mismatch         (mismatch)
    );

    always #5 clk = ~clk;

    instruction_t mem [32];

    // Registered-read register file model
    always @(posedge clk) instruction_word <= mem[read_pointer];

    typedef struct {
        logic [4:0]   addr;
        instruction_t word;
    } exp_t;

    typedef struct {
        int first;
        int cnt;
        int hold;
        bit rnd;
        bit pester;
        int exp_n;
        int exp_last;
        int exp_busy;
        int exp_lat;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   n_xfer;
    int   mm_cnt;
    int   last_addr;
    bit   mon_en;
    bit   mm_pend;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint tb_result(opcode_t o, operand_t a,
                                         operand_t b);
        longint x = a;
        longint y = b;
        case (o)
            PASSA:   return x;
            PASSB:   return y;
            ADD:     return x + y;
            SUB:     return x - y;
            MULT:    return x * y;
            DIV:     return (y == 0) ? 0 : x / y;
            MOD:     return (y == 0) ? 0 : x % y;
            default: return 0;
        endcase
    endfunction

    task automatic fill_random(input bit corrupt);
        for (int i = 0; i < 32; i++) begin
            mem[i].opc  = opcode_t'($urandom_range(0, 7));
            mem[i].op_a = operand_t'($urandom);
            mem[i].op_b = ($urandom_range(0, 3) == 0) ?
                          '0 : operand_t'($urandom_range(1, 200));
            mem[i].rez  = tb_result(mem[i].opc, mem[i].op_a, mem[i].op_b);
            if (corrupt && $urandom_range(0, 3) == 0)
                mem[i].rez = mem[i].rez + 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            mm_pend = 1'b0;
        end else if (mon_en) begin
            chk("mismatch", mismatch, mm_pend);
            if (mismatch) mm_cnt++;
            mm_pend = 1'b0;
            if (out_valid && out_ready) begin
                n_xfer++;
                last_addr = out_addr;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_xfer: got addr %0d expected none",
                             out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_addr", out_addr, e.addr);
                    chk("out_word", out_word, e.word);
`ifdef INSTR_READBACK_CHECK_EN
                    mm_pend = (e.word.rez != tb_result(e.word.opc,
                               e.word.op_a, e.word.op_b));
`endif
                end
            end
        end
    end

    task automatic run_row(input vec_t v);
        int  eff, a, x0, m0, exp_mm;
        int  busy_c, lat, dones, done_at;
        bit  fin;
        eff    = (v.cnt > 32) ? 32 : v.cnt;
        exp_mm = 0;
        for (int i = 0; i < eff; i++) begin
            a = (v.first + i) % 32;
            exp_q.push_back('{addr: 5'(a), word: mem[a]});
`ifdef INSTR_READBACK_CHECK_EN
            if (mem[a].rez != tb_result(mem[a].opc, mem[a].op_a, mem[a].op_b))
                exp_mm++;
`endif
        end
        x0 = n_xfer; m0 = mm_cnt; last_addr = -1;
        busy_c = 0; lat = -1; dones = 0; done_at = -1; fin = 0;
        @(posedge clk); #1;
        first_addr = 5'(v.first);
        count      = 6'(v.cnt);
        start      = 1'b1;
        out_ready  = (v.hold > 0) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start = v.pester;
        if (v.pester) begin
            first_addr = 5'((v.first + 9) % 32);
            count      = 6'd0;
        end
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk); #1;
            if (!busy) begin
                fin = 1;
                break;
            end
            busy_c++;
            if (out_valid && lat < 0) lat = k - 1;
            if (done) begin
                dones++;
                done_at = k;
            end
            if (v.hold > 0 && k >= 3 && k <= v.hold) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_addr", out_addr, 5'(v.first));
                chk("stall_word", out_word, exp_q[0].word);
            end
            if (k == v.hold)
                chk("stall_ptr", read_pointer, 5'((v.first + 4) % 32));
            @(posedge clk); #1;
            start = v.pester && (k < 3);
            if (k + 1 <= v.hold)
                out_ready = 1'b0;
            else
                out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("drain_finished", fin, 1'b1);
        chk("n_xfers", n_xfer - x0, v.exp_n);
        chk("last_addr", last_addr, v.exp_last);
        chk("done_count", dones, 1);
        chk("done_in_last_busy", done_at, busy_c);
        chk("first_latency", lat, v.exp_lat);
        if (v.exp_busy >= 0) chk("busy_cycles", busy_c, v.exp_busy);
        chk("queue_left", exp_q.size(), 0);
        chk("idle_valid", out_valid, 1'b0);
        chk("mm_pulses", mm_cnt - m0, exp_mm);
        exp_q.delete();
    endtask

    vec_t tbl [10];

    initial begin
        int  x0, dc;
        bit  hit;
        vec_t v;
        tbl[0] = '{0, 4, 0, 0, 0, 4, 3, 6, 2};
        tbl[1] = '{30, 4, 0, 0, 0, 4, 1, 6, 2};
        tbl[2] = '{5, 40, 0, 0, 0, 32, 4, 34, 2};
        tbl[3] = '{31, 1, 0, 0, 0, 1, 31, 3, 2};
        tbl[4] = '{12, 0, 0, 0, 0, 0, -1, 1, -1};
        tbl[5] = '{3, 5, 0, 0, 1, 5, 7, 7, 2};
        tbl[6] = '{10, 8, 10, 0, 0, 8, 17, -1, 2};
        tbl[7] = '{20, 32, 0, 1, 0, 32, 19, -1, 2};
        tbl[8] = '{0, 33, 0, 0, 0, 32, 31, 34, 2};
        tbl[9] = '{8, 2, 0, 0, 0, 2, 9, 4, 2};

        n_vec = 0; n_err = 0; n_xfer = 0; mm_cnt = 0;
        mon_en = 0; mm_pend = 0; last_addr = -1;
        clk = 0; reset_n = 0; start = 0;
        first_addr = '0; count = '0; out_ready = 1'b1;

        fill_random(1'b0);
        for (int i = 0; i < 4; i++)
            mem[i] = '{opc: ADD, op_a: 5, op_b: 3, rez: 8};
        mem[8] = '{opc: MULT, op_a: 6, op_b: 7, rez: 41};
        mem[9] = '{opc: DIV, op_a: 9, op_b: 0, rez: 0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_read_pointer", read_pointer, 5'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, '0);
        chk("rst_out_addr", out_addr, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mismatch", mismatch, 1'b0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int r = 0; r < 10; r++) run_row(tbl[r]);

        // Reset in the middle of a 10-entry drain
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{addr: 5'(7 + i), word: mem[7 + i]});
        x0 = n_xfer; hit = 0;
        @(posedge clk); #1;
        first_addr = 5'd7; count = 6'd10; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (n_xfer - x0 >= 3) begin
                hit = 1;
                break;
            end
        end
        chk("mid_reset_reached", hit, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ptr", read_pointer, 5'd0);
        exp_q.delete();
        dc = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done) dc++;
        end
        chk("mid_rst_no_done", dc, 0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        run_row(tbl[0]);
        run_row(tbl[1]);

        for (int it = 0; it < 15; it++) begin
            fill_random(1'b1);
            v.first  = $urandom_range(0, 31);
            v.cnt    = $urandom_range(0, 40);
            v.hold   = 0;
            v.rnd    = 1'b1;
            v.pester = (v.cnt >= 2) && ($urandom_range(0, 1) == 1);
            v.exp_n  = (v.cnt > 32) ? 32 : v.cnt;
            v.exp_last = (v.exp_n > 0) ? (v.first + v.exp_n - 1) % 32 : -1;
            v.exp_busy = -1;
            v.exp_lat  = (v.exp_n > 0) ? 2 : -1;
            run_row(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
